// File: rtl/key_scan.sv
// Debounced single-key scanner: synchronizes an active-low raw key, filters
// bounce in both directions, and reports press/release/short/long strobes.
module key_scan #(
  parameter int DEBOUNCE_CNT = 1000000,
  parameter int LONG_CNT     = 50000000
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       key_in,
  output logic       key_state,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       short_pulse,
  output logic       long_pulse,
  output logic [7:0] press_cnt
);

  localparam int DB_W   = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam int HOLD_W = (LONG_CNT > 1) ? $clog2(LONG_CNT) : 1;
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CNT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CNT - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    PRESSED,
    RELEASE_DB
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        sync_q, sync_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              long_done_q, long_done_d;
  logic              key_state_q, key_state_d;
  logic              press_pulse_q, press_pulse_d;
  logic              release_pulse_q, release_pulse_d;
  logic              short_pulse_q, short_pulse_d;
  logic              long_pulse_q, long_pulse_d;
  logic [7:0]        press_cnt_q, press_cnt_d;
  logic              key_sync;

  // sync_q[1] is the second synchronizer stage; idle level of the key is 1
  assign sync_d   = {sync_q[0], key_in};
  assign key_sync = sync_q[1];

  always_comb begin
    state_d         = state_q;
    db_cnt_d        = db_cnt_q;
    hold_cnt_d      = hold_cnt_q;
    long_done_d     = long_done_q;
    key_state_d     = key_state_q;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;
    short_pulse_d   = 1'b0;
    long_pulse_d    = 1'b0;
    press_cnt_d     = press_cnt_q;

    // Hold time runs through release debounce so a bounced release does not reset it
    if (state_q == PRESSED || state_q == RELEASE_DB) begin
      if (hold_cnt_q != HOLD_LAST) begin
        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
      end
      if (hold_cnt_d == HOLD_LAST && !long_done_q) begin
        long_pulse_d = 1'b1;
        long_done_d  = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (!key_sync) begin
          state_d  = PRESS_DB;
          db_cnt_d = '0;
        end
      end
      PRESS_DB: begin
        if (key_sync) begin
          state_d = IDLE;
        end else if (db_cnt_q == DB_LAST) begin
          state_d       = PRESSED;
          key_state_d   = 1'b1;
          press_pulse_d = 1'b1;
          hold_cnt_d    = '0;
          long_done_d   = 1'b0;
          press_cnt_d   = press_cnt_q + 8'd1;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      PRESSED: begin
        if (key_sync) begin
          state_d  = RELEASE_DB;
          db_cnt_d = '0;
        end
      end
      RELEASE_DB: begin
        if (!key_sync) begin
          state_d = PRESSED;
        end else if (db_cnt_q == DB_LAST) begin
          state_d         = IDLE;
          key_state_d     = 1'b0;
          release_pulse_d = 1'b1;
          // long_done_d already reflects a long press firing on this same edge
          short_pulse_d   = !long_done_d;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      sync_q          <= 2'b11;
      db_cnt_q        <= '0;
      hold_cnt_q      <= '0;
      long_done_q     <= 1'b0;
      key_state_q     <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      short_pulse_q   <= 1'b0;
      long_pulse_q    <= 1'b0;
      press_cnt_q     <= 8'd0;
    end else begin
      state_q         <= state_d;
      sync_q          <= sync_d;
      db_cnt_q        <= db_cnt_d;
      hold_cnt_q      <= hold_cnt_d;
      long_done_q     <= long_done_d;
      key_state_q     <= key_state_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      short_pulse_q   <= short_pulse_d;
      long_pulse_q    <= long_pulse_d;
      press_cnt_q     <= press_cnt_d;
    end
  end

  assign key_state     = key_state_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;
  assign short_pulse   = short_pulse_q;
  assign long_pulse    = long_pulse_q;
  assign press_cnt     = press_cnt_q;

endmodule

// File: tb/tb_key_scan.sv
// Directed bench for key_scan with DEBOUNCE_CNT=4, LONG_CNT=20; pulse arrival
// edges are counted relative to the edge after which key_in was changed.
module tb_key_scan;

  logic       sys_clk = 1'b0;
  logic       rst_n;
  logic       key_in;
  logic       key_state;
  logic       press_pulse;
  logic       release_pulse;
  logic       short_pulse;
  logic       long_pulse;
  logic [7:0] press_cnt;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int press_n, rel_n, short_n, long_n;
  int press_at, rel_at, short_at, long_at;
  int t0;

  key_scan #(.DEBOUNCE_CNT(4), .LONG_CNT(20)) dut (
    .sys_clk      (sys_clk),
    .rst_n        (rst_n),
    .key_in       (key_in),
    .key_state    (key_state),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .short_pulse  (short_pulse),
    .long_pulse   (long_pulse),
    .press_cnt    (press_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Each high sample counts once, so a pulse lasting two cycles shows up as an extra count
  always @(negedge sys_clk) begin
    if (press_pulse)   begin press_n++; press_at = cyc; end
    if (release_pulse) begin rel_n++;   rel_at   = cyc; end
    if (short_pulse)   begin short_n++; short_at = cyc; end
    if (long_pulse)    begin long_n++;  long_at  = cyc; end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic clr();
    press_n = 0; rel_n = 0; short_n = 0; long_n = 0;
    press_at = -1; rel_at = -1; short_at = -1; long_at = -1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    clr();
    rst_n  = 1'b0;
    key_in = 1'b1;
    tick(3);
    chk("reset_outputs", int'({key_state, press_pulse, release_pulse, short_pulse, long_pulse}), 0);
    chk("reset_press_cnt", int'(press_cnt), 0);
    rst_n = 1'b1;
    tick(5);
    chk("idle_press_n", press_n, 0);

    // Long hold: low 30 cycles then released
    clr(); t0 = cyc; key_in = 1'b0;
    tick(30); key_in = 1'b1; tick(12);
    $display("txn long_hold press@%0d long@%0d rel@%0d", press_at - t0, long_at - t0, rel_at - t0);
    chk("long_press_n", press_n, 1);
    chk("long_press_at", press_at - t0, 7);
    chk("long_long_n", long_n, 1);
    chk("long_long_at", long_at - t0, 26);
    chk("long_rel_n", rel_n, 1);
    chk("long_rel_at", rel_at - t0, 37);
    chk("long_short_n", short_n, 0);
    chk("long_press_cnt", int'(press_cnt), 1);
    chk("long_key_state_after", int'(key_state), 0);

    // Short press: low 10 cycles
    clr(); t0 = cyc; key_in = 1'b0;
    tick(10);
    chk("short_key_state_held", int'(key_state), 1);
    key_in = 1'b1; tick(12);
    $display("txn short_press press@%0d rel@%0d short@%0d", press_at - t0, rel_at - t0, short_at - t0);
    chk("short_press_at", press_at - t0, 7);
    chk("short_rel_at", rel_at - t0, 17);
    chk("short_short_n", short_n, 1);
    chk("short_short_at", short_at - t0, 17);
    chk("short_long_n", long_n, 0);
    chk("short_press_cnt", int'(press_cnt), 2);
    chk("short_key_state_after", int'(key_state), 0);

    // Low glitches of 1, 2 and 3 cycles
    clr();
    key_in = 1'b0; tick(1); key_in = 1'b1; tick(3);
    key_in = 1'b0; tick(2); key_in = 1'b1; tick(3);
    key_in = 1'b0; tick(3); key_in = 1'b1; tick(8);
    $display("txn glitches press_n=%0d rel_n=%0d", press_n, rel_n);
    chk("glitch_press_n", press_n, 0);
    chk("glitch_rel_n", rel_n, 0);
    chk("glitch_key_state", int'(key_state), 0);
    chk("glitch_press_cnt", int'(press_cnt), 2);

    // Held press with a 2-cycle high glitch
    clr(); t0 = cyc; key_in = 1'b0;
    tick(12); key_in = 1'b1; tick(2); key_in = 1'b0; tick(6);
    chk("rglitch_key_state", int'(key_state), 1);
    chk("rglitch_rel_n_mid", rel_n, 0);
    tick(10); key_in = 1'b1; tick(12);
    $display("txn release_glitch long@%0d rel@%0d", long_at - t0, rel_at - t0);
    chk("rglitch_long_at", long_at - t0, 26);
    chk("rglitch_long_n", long_n, 1);
    chk("rglitch_rel_n", rel_n, 1);
    chk("rglitch_rel_at", rel_at - t0, 37);
    chk("rglitch_short_n", short_n, 0);
    chk("rglitch_press_cnt", int'(press_cnt), 3);

    // Release acceptance on the same edge as the long threshold
    clr(); t0 = cyc; key_in = 1'b0;
    tick(19); key_in = 1'b1; tick(12);
    $display("txn coincide long@%0d rel@%0d short_n=%0d", long_at - t0, rel_at - t0, short_n);
    chk("coin_long_at", long_at - t0, 26);
    chk("coin_rel_at", rel_at - t0, 26);
    chk("coin_short_n", short_n, 0);
    chk("coin_press_cnt", int'(press_cnt), 4);

    // Reset during PRESSED, key still held through reset release
    clr(); t0 = cyc; key_in = 1'b0;
    tick(12);
    chk("rst_pre_key_state", int'(key_state), 1);
    rst_n = 1'b0; #1;
    chk("rst_outputs", int'({key_state, press_pulse, release_pulse, short_pulse, long_pulse}), 0);
    chk("rst_press_cnt", int'(press_cnt), 0);
    tick(3);
    clr(); rst_n = 1'b1; t0 = cyc;
    tick(1);
    chk("rst_first_edge_pulses", press_n + rel_n + short_n + long_n, 0);
    tick(9);
    $display("txn post_reset press@%0d", press_at - t0);
    chk("rst_press_at", press_at - t0, 7);
    chk("rst_rel_n_none", rel_n, 0);
    key_in = 1'b1; tick(12);
    chk("rst_short_n", short_n, 1);
    chk("rst_press_cnt_after", int'(press_cnt), 1);

    // 256 clean short presses wrap the counter back to its start
    clr();
    for (int i = 1; i <= 256; i++) begin
      key_in = 1'b0; tick(8);
      key_in = 1'b1; tick(10);
      if (i == 255) chk("wrap_press_cnt_255", int'(press_cnt), 0);
    end
    $display("txn burst256 press_n=%0d short_n=%0d press_cnt=%0d", press_n, short_n, press_cnt);
    chk("burst_press_n", press_n, 256);
    chk("burst_short_n", short_n, 256);
    chk("burst_rel_n", rel_n, 256);
    chk("burst_long_n", long_n, 0);
    chk("burst_press_cnt", int'(press_cnt), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
